// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-input / pipeline-control bundle between the 5-stage pipeline datapath
// and its central stall/flush controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
);
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic                      id_uses_rs1;
  logic                      id_uses_rs2;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_mem_read;
  logic                      ex_branch_taken;
  logic                      imem_ready;
  logic                      dmem_busy;
  logic                      perf_clr;

  logic                      pc_en;
  logic                      if_id_en;
  logic                      id_ex_en;
  logic                      ex_mem_en;
  logic                      if_id_flush;
  logic                      id_ex_flush;
  logic                      mem_wb_flush;
  logic [2:0]                ctrl_state;
  logic [CNT_WIDTH-1:0]      stall_cycles;
  logic [CNT_WIDTH-1:0]      flush_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, imem_ready, dmem_busy, perf_clr,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           mem_wb_flush, ctrl_state, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, imem_ready, dmem_busy, perf_clr,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           mem_wb_flush, ctrl_state, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: classifies each cycle (mem wait, redirect,
// load-use, fetch wait, run) and drives pipeline register enables/flushes.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32,
  parameter int INIT_CYCLES    = 2
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_RUN        = 3'd1,
    S_LOAD_STALL = 3'd2,
    S_MEM_WAIT   = 3'd3,
    S_FETCH_WAIT = 3'd4,
    S_REDIRECT   = 3'd5
  } state_t;

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  state_t               state, state_nxt, cls;
  logic [3:0]           init_cnt, init_cnt_nxt;
  logic                 load_use;
  logic                 pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic                 if_id_flush, id_ex_flush, mem_wb_flush;
  logic                 stall_inc, flush_inc;
  logic [CNT_WIDTH-1:0] stall_cycles, flush_count;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    load_use = bus.ex_mem_read && (bus.ex_rd != '0) &&
               ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));
  end

  // Priority classification; a busy MEM stage freezes everything upstream,
  // so any branch or load-use seen meanwhile is simply handled afterwards.
  always_comb begin
    cls = S_RUN;
    if (bus.dmem_busy)            cls = S_MEM_WAIT;
    else if (bus.ex_branch_taken) cls = S_REDIRECT;
    else if (load_use)            cls = S_LOAD_STALL;
    else if (!bus.imem_ready)     cls = S_FETCH_WAIT;
  end

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    if_id_flush  = 1'b1;
    id_ex_flush  = 1'b1;
    mem_wb_flush = 1'b1;
    if (state != S_INIT) begin
      unique case (cls)
        S_MEM_WAIT: begin
          if_id_flush  = 1'b0;
          id_ex_flush  = 1'b0;
        end
        S_REDIRECT: begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b1111;
          mem_wb_flush = 1'b0;
        end
        S_LOAD_STALL: begin
          {id_ex_en, ex_mem_en} = 2'b11;
          if_id_flush  = 1'b0;
          mem_wb_flush = 1'b0;
        end
        S_FETCH_WAIT: begin
          {if_id_en, id_ex_en, ex_mem_en} = 3'b111;
          id_ex_flush  = 1'b0;
          mem_wb_flush = 1'b0;
        end
        default: begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b1111;
          {if_id_flush, id_ex_flush, mem_wb_flush} = 3'b000;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt    = cls;
    init_cnt_nxt = init_cnt;
    if (state == S_INIT) begin
      state_nxt = S_INIT;
      if (init_cnt == INIT_LAST) state_nxt = cls;
      else                       init_cnt_nxt = init_cnt + 4'd1;
    end
  end

  always_comb begin
    stall_inc = (state != S_INIT) && !pc_en;
    flush_inc = (state != S_INIT) && (cls == S_REDIRECT);
  end

  // ---- state / counter register stage ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_INIT;
      init_cnt     <= 4'd0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
      if (bus.perf_clr) begin
        stall_cycles <= '0;
        flush_count  <= '0;
      end else begin
        if (stall_inc) stall_cycles <= sat_inc(stall_cycles);
        if (flush_inc) flush_count  <= sat_inc(flush_count);
      end
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.ctrl_state   = state;
  assign bus.stall_cycles = stall_cycles;
  assign bus.flush_count  = flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with a queue scoreboard;
// 4-bit counters so saturation is reachable quickly.
module tb_pipeline_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 4;

  // Control vector: {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush}
  localparam logic [6:0] C_INIT  = 7'b0000111;
  localparam logic [6:0] C_RUN   = 7'b1111000;
  localparam logic [6:0] C_MEMW  = 7'b0000001;
  localparam logic [6:0] C_REDIR = 7'b1111110;
  localparam logic [6:0] C_LOADS = 7'b0011010;
  localparam logic [6:0] C_FETCH = 7'b0111100;

  typedef struct {
    int         idx;
    logic [6:0] ctl;
    logic [2:0] st;
    logic [3:0] stall;
    logic [3:0] fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   vec   = 0;
  exp_t q[$];

  pipeline_hazard_ctrl_if #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) bus ();

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW), .INIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs (just after the rising edge) and queue the expected response.
  task automatic cyc(input logic r, input logic br, input logic ir, input logic db,
                     input logic mr, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                     input logic [RW-1:0] rs2, input logic u1, input logic u2,
                     input logic clr, input logic [6:0] ectl, input logic [2:0] est,
                     input logic [3:0] estall, input logic [3:0] efl);
    exp_t e;
    rst                 = r;
    bus.ex_branch_taken = br;
    bus.imem_ready      = ir;
    bus.dmem_busy       = db;
    bus.ex_mem_read     = mr;
    bus.ex_rd           = rd;
    bus.id_rs1          = rs1;
    bus.id_rs2          = rs2;
    bus.id_uses_rs1     = u1;
    bus.id_uses_rs2     = u2;
    bus.perf_clr        = clr;
    e.idx = vec; e.ctl = ectl; e.st = est; e.stall = estall; e.fl = efl;
    q.push_back(e);
    vec++;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input logic r, input logic [6:0] ectl, input logic [2:0] est,
                       input logic [3:0] estall, input logic [3:0] efl);
    cyc(r, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, ectl, est, estall, efl);
  endtask

  // Monitor: the controller presents a response every cycle; sample mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = q.pop_front();
      act = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
             bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush};
      tests++;
      if (act !== e.ctl) begin
        fails++;
        $display("FAIL ctl vec %0d: got %b expected %b", e.idx, act, e.ctl);
      end
      tests++;
      if (bus.ctrl_state !== e.st) begin
        fails++;
        $display("FAIL state vec %0d: got %0d expected %0d", e.idx, bus.ctrl_state, e.st);
      end
      tests++;
      if (bus.stall_cycles !== e.stall) begin
        fails++;
        $display("FAIL stall_cycles vec %0d: got %0d expected %0d", e.idx, bus.stall_cycles, e.stall);
      end
      tests++;
      if (bus.flush_count !== e.fl) begin
        fails++;
        $display("FAIL flush_count vec %0d: got %0d expected %0d", e.idx, bus.flush_count, e.fl);
      end
    end
  end

  initial begin
    bus.ex_branch_taken = 1'b0; bus.imem_ready = 1'b1; bus.dmem_busy = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_rd = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0; bus.perf_clr = 1'b0;
    @(posedge clk);
    #1;
    // Held in reset, even with a busy MEM stage.
    quiet(0, C_INIT, 3'd0, 4'd0, 4'd0);
    cyc(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_INIT, 3'd0, 4'd0, 4'd0);
    // Release: two INIT edges, then RUN.
    quiet(1, C_INIT, 3'd0, 4'd0, 4'd0);
    quiet(1, C_INIT, 3'd0, 4'd0, 4'd0);
    quiet(1, C_RUN,  3'd1, 4'd0, 4'd0);
    // Load-use on rs2 with fetch also stalled: IF/ID held, not flushed.
    cyc(1, 0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0, C_LOADS, 3'd1, 4'd0, 4'd0);
    quiet(1, C_RUN, 3'd2, 4'd1, 4'd0);
    // Load to x0 is not a hazard.
    cyc(1, 0, 1, 0, 1, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_RUN, 3'd1, 4'd1, 4'd0);
    // Load-use on rs1, then the same registers with the use flag cleared.
    cyc(1, 0, 1, 0, 1, 5'd7, 5'd7, 5'd0, 1, 0, 0, C_LOADS, 3'd1, 4'd1, 4'd0);
    cyc(1, 0, 1, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, C_RUN,   3'd2, 4'd2, 4'd0);
    // Redirect ignores imem_ready.
    cyc(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_REDIR, 3'd1, 4'd2, 4'd0);
    // Branch frozen behind 3 busy MEM cycles, then redirects once.
    cyc(1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_MEMW,  3'd5, 4'd2, 4'd1);
    cyc(1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_MEMW,  3'd3, 4'd3, 4'd1);
    cyc(1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_MEMW,  3'd3, 4'd4, 4'd1);
    cyc(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_REDIR, 3'd3, 4'd5, 4'd1);
    quiet(1, C_RUN, 3'd5, 4'd5, 4'd2);
    // MEM wait beats load-use; load-use beats fetch wait.
    cyc(1, 0, 1, 1, 1, 5'd3, 5'd3, 5'd0, 1, 0, 0, C_MEMW,  3'd1, 4'd5, 4'd2);
    cyc(1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 0, C_LOADS, 3'd3, 4'd6, 4'd2);
    // 20 fetch-wait cycles: stall counter saturates at 15.
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_FETCH,
          (i == 0) ? 3'd2 : 3'd4, (7 + i > 15) ? 4'd15 : 4'(7 + i), 4'd2);
    end
    // Clear together with another stall: clear wins.
    cyc(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, C_FETCH, 3'd4, 4'd15, 4'd2);
    quiet(1, C_RUN, 3'd4, 4'd0, 4'd0);
    quiet(1, C_RUN, 3'd1, 4'd0, 4'd0);
    // Asynchronous reset in the middle of a MEM wait.
    cyc(1, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_MEMW, 3'd1, 4'd0, 4'd0);
    cyc(1, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_MEMW, 3'd3, 4'd1, 4'd0);
    cyc(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_INIT, 3'd0, 4'd0, 4'd0);
    quiet(1, C_INIT, 3'd0, 4'd0, 4'd0);
    quiet(1, C_INIT, 3'd0, 4'd0, 4'd0);
    quiet(1, C_RUN,  3'd1, 4'd0, 4'd0);
    // Redirect beats a simultaneous load-use and fetch wait.
    cyc(1, 1, 0, 0, 1, 5'd9, 5'd9, 5'd9, 1, 1, 0, C_REDIR, 3'd1, 4'd0, 4'd0);
    quiet(1, C_RUN, 3'd5, 4'd0, 4'd1);

    for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d responses left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
